f_pred_pc: RTL and testbench

Fetch-stage PC predictor and F pipeline register for the Y86-64 pipelined core. Each unstalled cycle it computes the next predicted PC from the instruction being fetched and registers it as `F_predPC`; the PC-select logic then consumes `F_predPC` and overrides it on a jXX mispredict from M or a `ret` resolution from W. An optional return-address stack (RAS) predicts `ret` targets so that `ret` need not be resolved in W before fetch can continue.

---
 rtl/y86_pkg.sv | 17 +
 rtl/ras_stack.sv | 53 +++++
 rtl/f_pred_pc.sv | 91 +++++++++
 tb/tb_f_pred_pc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: word width, word type and the instruction codes
// used by the fetch-stage predictor.
package y86_pkg;

  localparam int WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [3:0]        icode_t;

  localparam icode_t IHALT   = 4'h0;
  localparam icode_t INOP    = 4'h1;
  localparam icode_t IRRMOVQ = 4'h2;
  localparam icode_t IJXX    = 4'h7;
  localparam icode_t ICALL   = 4'h8;
  localparam icode_t IRET    = 4'h9;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// the count saturates at RAS_DEPTH, and clear wins over a same-cycle push/pop.
module ras_stack
  import y86_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  word_t                      i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output word_t                      o_top,
  output logic [$clog2(RAS_DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(RAS_DEPTH);

  word_t            r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr is the next free slot; wrapping it makes a full push land on the oldest entry.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (r_count != FULL) r_count <= r_count + (PTR_W + 1)'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PTR_W + 1)'(1);
    end
  end

  // NOTE: the entry array has no reset; only slots below r_count are ever read.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_ptr] <= i_push_data;
  end

endmodule

// File: rtl/f_pred_pc.sv
// Fetch-stage next-PC predictor and F pipeline register. Define F_PRED_RAS_EN
// to add a return-address stack that predicts ret targets.
module f_pred_pc
  import y86_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WORD_W-1:0]          f_pc,
  input  logic [3:0]                 f_icode,
  input  logic [WORD_W-1:0]          f_valC,
  input  logic [WORD_W-1:0]          f_valP,
  input  logic                       F_stall,
  input  logic [3:0]                 M_icode,
  input  logic                       M_Cnd,
  output logic [WORD_W-1:0]          F_predPC,
  output logic                       ras_pred,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  word_t r_pred_pc;
  logic  r_ras_pred;
  word_t w_next_pc;
  logic  w_next_ras;
  word_t w_top;
  logic  w_ret_hit;
  logic  w_unused;

`ifdef F_PRED_RAS_EN
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;

  assign w_ret_hit = (f_icode == IRET) && (w_count != '0);
  assign w_push    = !F_stall && (f_icode == ICALL);
  assign w_pop     = !F_stall && w_ret_hit;
  // A not-taken jXX in M means F holds a wrong-path instruction; drop the stack even when stalled.
  assign w_clear   = (M_icode == IJXX) && !M_Cnd;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (f_valP),
    .i_pop       (w_pop),
    .i_clear     (w_clear),
    .o_top       (w_top),
    .o_count     (w_count)
  );

  assign ras_count = w_count;
  assign w_unused  = ^f_pc;
`else
  assign w_ret_hit = 1'b0;
  assign w_top     = '0;
  assign ras_count = '0;
  assign w_unused  = ^{f_pc, M_icode, M_Cnd};
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_pc  = f_valP;
    w_next_ras = 1'b0;
    if ((f_icode == IJXX) || (f_icode == ICALL)) begin
      w_next_pc = f_valC;
    end else if (w_ret_hit) begin
      w_next_pc  = w_top;
      w_next_ras = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_pc  <= '0;
      r_ras_pred <= 1'b0;
    end else if (!F_stall) begin
      r_pred_pc  <= w_next_pc;
      r_ras_pred <= w_next_ras;
    end
  end

  assign F_predPC = r_pred_pc;
  assign ras_pred = r_ras_pred;

endmodule

// File: tb/tb_f_pred_pc.sv
// Scoreboard bench for f_pred_pc: a queue-based reference model produces the
// expected registered outputs; a monitor compares them one cycle later.
module tb_f_pred_pc;
  import y86_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef F_PRED_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  word_t            f_pc, f_valC, f_valP;
  logic [3:0]       f_icode, M_icode;
  logic             F_stall, M_Cnd;
  word_t            F_predPC;
  logic             ras_pred;
  logic [CNT_W-1:0] ras_count;

  f_pred_pc #(.RAS_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_pc      (f_pc),
    .f_icode   (f_icode),
    .f_valC    (f_valC),
    .f_valP    (f_valP),
    .F_stall   (F_stall),
    .M_icode   (M_icode),
    .M_Cnd     (M_Cnd),
    .F_predPC  (F_predPC),
    .ras_pred  (ras_pred),
    .ras_count (ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t pc;
    logic  rp;
    int    cnt;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  word_t m_ras[$];
  word_t m_pc;
  logic  m_rp;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic word_t rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_rp = 1'b0;
    m_ras.delete();
  endtask

  // One F-stage cycle: drive inputs, advance the model, queue the expected outputs.
  task automatic apply(input logic [3:0] ic, input word_t vc, input word_t vp, input logic st,
                       input logic [3:0] mi, input logic mc, input string tag);
    bit avail;
    @(negedge clk);
    f_icode = ic; f_valC = vc; f_valP = vp; F_stall = st;
    M_icode = mi; M_Cnd = mc; f_pc = rnd_word();
    avail = RAS_ON && (m_ras.size() > 0);
    if (!st) begin
      if (ic == IJXX || ic == ICALL) m_pc = vc;
      else if (ic == IRET && avail)  m_pc = m_ras[$];
      else                           m_pc = vp;
      m_rp = (ic == IRET) && avail;
    end
    if (RAS_ON) begin
      if (mi == IJXX && !mc) begin
        m_ras.delete();
      end else if (!st) begin
        if (ic == ICALL) begin
          m_ras.push_back(vp);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ic == IRET && avail) begin
          void'(m_ras.pop_back());
        end
      end
    end
    exp_q.push_back('{pc: m_pc, rp: m_rp, cnt: m_ras.size(), tag: tag});
  endtask

  task automatic op(input logic [3:0] ic, input word_t vc, input word_t vp, input string tag);
    apply(ic, vc, vp, 1'b0, INOP, 1'b1, tag);
  endtask

  // Monitor: outputs settle one cycle after the inputs were applied.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc"},  F_predPC,        e.pc);
        check({e.tag, ".rp"},  64'(ras_pred),   64'(e.rp));
        check({e.tag, ".cnt"}, 64'(ras_count),  64'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [3:0] ic, mi;
    logic       st, mc;
    int         r;

    rst_n = 1'b0;
    f_pc = rnd_word(); f_valC = rnd_word(); f_valP = rnd_word();
    f_icode = ICALL; F_stall = 1'b0; M_icode = IRET; M_Cnd = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.pc",  F_predPC,       64'h0);
    check("reset.rp",  64'(ras_pred),  64'h0);
    check("reset.cnt", 64'(ras_count), 64'h0);
    rst_n = 1'b1;

    op(IRRMOVQ, 64'h55, 64'h0A, "irrmovq");
    op(IJXX,    64'h100, 64'h9, "jxx");
    op(ICALL,   64'h200, 64'h19, "call");
    op(IRET,    64'h0, 64'h1, "ret_after_call");

    apply(ICALL, 64'h300, 64'h2A, 1'b0, INOP, 1'b1, "pre_stall");
    repeat (3) apply(ICALL, 64'h400, 64'h3B, 1'b1, INOP, 1'b1, "stall_call");
    apply(ICALL, 64'h400, 64'h3B, 1'b0, INOP, 1'b1, "stall_release");
    op(IRET, 64'h0, 64'h7, "ret_after_stall");
    op(IRET, 64'h0, 64'h7, "ret_after_stall2");

    for (int i = 1; i <= 9; i++) op(ICALL, 64'h1000 + 64'(i), 64'(i), "ovf_call");
    for (int i = 0; i < 8; i++)  op(IRET, 64'h0, 64'hF0 + 64'(i), "ovf_ret");
    op(IRET, 64'h0, 64'hE1, "underflow_ret");

    op(ICALL, 64'h500, 64'h41, "fill");
    op(ICALL, 64'h510, 64'h42, "fill");
    apply(ICALL, 64'h600, 64'h43, 1'b0, IJXX, 1'b0, "flush_call");
    op(ICALL, 64'h700, 64'h44, "fill2");
    apply(ICALL, 64'h800, 64'h45, 1'b1, IJXX, 1'b0, "flush_stalled");
    apply(IRET, 64'h0, 64'h46, 1'b0, IJXX, 1'b1, "taken_jxx_no_flush");

    op(ICALL, 64'h900, 64'h33, "call_then_ret");
    op(IRET,  64'h0,   64'h33, "ret_valp33");

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      ic = ICALL;
      else if (r < 6) ic = IRET;
      else if (r < 7) ic = IJXX;
      else            ic = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) begin
        mi = IJXX; mc = 1'b0;
      end else begin
        mi = 4'($urandom_range(0, 11)); mc = 1'($urandom);
      end
      apply(ic, rnd_word(), rnd_word(), st, mi, mc, "random");
    end

    for (int i = 0; i < 4; i++) op(ICALL, rnd_word(), rnd_word(), "pre_async");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset.pc",  F_predPC,       64'h0);
    check("async_reset.rp",  64'(ras_pred),  64'h0);
    check("async_reset.cnt", 64'(ras_count), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op(IRET, 64'h0, 64'h77, "ret_after_reset");
    op(IRRMOVQ, 64'h0, 64'h88, "seq_after_reset");

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
